// File: rtl/vga_pkg.sv
// Shared VGA definitions: axis-state type, default 1024x768@60 timing and the
// RGB332 palette used by the timing generator and the draw blocks.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  localparam logic [7:0] RGB_BLACK  = 8'h00;
  localparam logic [7:0] RGB_WHITE  = 8'hFF;
  localparam logic [7:0] RGB_RED    = 8'hE0;
  localparam logic [7:0] RGB_PURPLE = 8'hE3;

  // Colour of vertical test bar idx (0 = leftmost).
  function automatic logic [7:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = RGB_BLACK;
      3'd1:    bar_colour = RGB_RED;
      3'd2:    bar_colour = 8'h1C;
      3'd3:    bar_colour = 8'h03;
      3'd4:    bar_colour = 8'hFC;
      3'd5:    bar_colour = RGB_PURPLE;
      3'd6:    bar_colour = 8'h1F;
      default: bar_colour = RGB_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// Single raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK state,
// stepping on adv_i. state_d_o is the state that goes with the next count.
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned W      = 11
) (
  input  logic         vclk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  output logic [W-1:0] count_o,
  output axis_state_e  state_d_o,
  output logic         wrap_o
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] A_END = W'(ACTIVE - 1);
  localparam logic [W-1:0] F_END = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] S_END = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);

  if (TOTAL > (32'd1 << W)) begin : g_range_err
    $error("vga_axis_fsm: axis total does not fit the counter width");
  end

  logic [W-1:0] count_q, count_d;
  axis_state_e  state_q, state_d;
  logic         wrap;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    wrap    = 1'b0;
    if (adv_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      case (state_q)
        ST_ACTIVE: if (count_q == A_END) state_d = ST_FRONT;
        ST_FRONT:  if (count_q == F_END) state_d = ST_SYNC;
        ST_SYNC:   if (count_q == S_END) state_d = ST_BACK;
        default:   if (count_q == LAST)  state_d = ST_ACTIVE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge vclk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      state_q <= ST_ACTIVE;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count_o   = count_q;
  assign state_d_o = state_d;
  assign wrap_o    = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: hcount/vcount with zero-skew registered sync,
// blank and line/frame pulses. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        vclk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        line_start,
  output logic [7:0]  test_pixel
);

  axis_state_e h_state_d, v_state_d;
  logic        h_wrap, v_wrap;

  vga_axis_fsm #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)
  ) u_h_axis (
    .vclk_i   (vclk),
    .rst_i    (rst),
    .adv_i    (pix_en),
    .count_o  (hcount),
    .state_d_o(h_state_d),
    .wrap_o   (h_wrap)
  );

  // The vertical axis steps once per completed line.
  vga_axis_fsm #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)
  ) u_v_axis (
    .vclk_i   (vclk),
    .rst_i    (rst),
    .adv_i    (h_wrap),
    .count_o  (vcount),
    .state_d_o(v_state_d),
    .wrap_o   (v_wrap)
  );

  logic hsync_d, vsync_d, blank_d;
  logic hsync_q, vsync_q, blank_q, line_start_q, frame_start_q;

  assign hsync_d = (h_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync_d = (v_state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign blank_d = (h_state_d != ST_ACTIVE) | (v_state_d != ST_ACTIVE);

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [10:0] h_next;
  logic [7:0]  test_pixel_d, test_pixel_q;

  always_comb begin
    h_next = hcount;
    if (pix_en) h_next = h_wrap ? '0 : hcount + 11'd1;
  end

  assign test_pixel_d = blank_d ? RGB_BLACK : bar_colour(h_next[9:7]);

  always_ff @(posedge vclk or posedge rst) begin
    if (rst) test_pixel_q <= RGB_BLACK;
    else     test_pixel_q <= test_pixel_d;
  end

  assign test_pixel = test_pixel_q;
`else
  assign test_pixel = RGB_BLACK;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default line timing, a shortened
// 20-line frame (V 12/2/3/3) so the whole frame stays short.
module tb_vga_timing_gen;

  localparam int H_TOT = 1344;
  localparam int V_TOT = 20;
  localparam int FRAME = H_TOT * V_TOT;

  logic        vclk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank, frame_start, line_start;
  logic [7:0]  test_pixel;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_gen #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3)
  ) dut (
    .vclk       (vclk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .frame_start(frame_start),
    .line_start (line_start),
    .test_pixel (test_pixel)
  );

  always #5 vclk = ~vclk;

  task automatic step();
    @(posedge vclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_h, exp_v;
    int bad_h, bad_v, bad_hs, bad_vs, bad_bl, bad_ls, bad_fs;
    int hs_cnt, hs_first, hs_last, vs_cnt, vs_first, vs_last;
    int fs_cnt, fs_h, fs_v, ls_cnt;
    logic [7:0] tp130, tp900, tp1100, exp130, exp900;
    int ls_seen, ls_t0, ls_t1, run_ls, run_fs, max_run, bad_hold, bad_pulse_off;
    logic [10:0] prev_h;

`ifdef VGA_TEST_PATTERN_EN
    exp130 = 8'hE0;
    exp900 = 8'hFF;
`else
    exp130 = 8'h00;
    exp900 = 8'h00;
`endif

    // Reset state
    rst = 1'b1;
    pix_en = 1'b0;
    repeat (3) step();
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank", blank, 0);
    check("rst_pulses", {frame_start, line_start}, 0);
    check("rst_test_pixel", test_pixel, 0);

    // Full frame sweep against a position model
    rst = 1'b0;
    pix_en = 1'b1;
    exp_h = 0; exp_v = 0;
    bad_h = 0; bad_v = 0; bad_hs = 0; bad_vs = 0; bad_bl = 0; bad_ls = 0; bad_fs = 0;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    vs_cnt = 0; vs_first = -1; vs_last = -1;
    fs_cnt = 0; fs_h = -1; fs_v = -1; ls_cnt = 0;
    tp130 = 8'hxx; tp900 = 8'hxx; tp1100 = 8'hxx;
    for (int i = 1; i <= FRAME; i++) begin
      step();
      exp_h = (exp_h == H_TOT - 1) ? 0 : exp_h + 1;
      if (exp_h == 0) exp_v = (exp_v == V_TOT - 1) ? 0 : exp_v + 1;
      if (hcount !== 11'(exp_h)) bad_h++;
      if (vcount !== 10'(exp_v)) bad_v++;
      if (hsync !== !(exp_h >= 1048 && exp_h <= 1183)) bad_hs++;
      if (vsync !== !(exp_v >= 14 && exp_v <= 16)) bad_vs++;
      if (blank !== (exp_h >= 1024 || exp_v >= 12)) bad_bl++;
      if (line_start !== (exp_h == 0)) bad_ls++;
      if (frame_start !== (exp_h == 0 && exp_v == 0)) bad_fs++;
      if (hsync === 1'b0 && exp_v == 0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcount);
        hs_last = int'(hcount);
      end
      if (vsync === 1'b0 && exp_h == 0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(vcount);
        vs_last = int'(vcount);
      end
      if (frame_start === 1'b1) begin
        fs_cnt++;
        fs_h = int'(hcount);
        fs_v = int'(vcount);
      end
      if (line_start === 1'b1) ls_cnt++;
      if (i == 130)  tp130  = test_pixel;
      if (i == 900)  tp900  = test_pixel;
      if (i == 1100) tp1100 = test_pixel;
      if (i == 1023) check("blank_h1023", blank, 0);
      if (i == 1024) check("blank_h1024", blank, 1);
      if (i == 1343) check("pos_end_of_line0", {5'd0, hcount, vcount}, {5'd0, 11'd1343, 10'd0});
      if (i == 1344) begin
        check("pos_wrap_line1", {5'd0, hcount, vcount}, {5'd0, 11'd0, 10'd1});
        check("line_start_first_line", ls_cnt, 1);
      end
    end
    check("sweep_hcount_errs", bad_h, 0);
    check("sweep_vcount_errs", bad_v, 0);
    check("sweep_hsync_errs", bad_hs, 0);
    check("sweep_vsync_errs", bad_vs, 0);
    check("sweep_blank_errs", bad_bl, 0);
    check("sweep_line_start_errs", bad_ls, 0);
    check("sweep_frame_start_errs", bad_fs, 0);
    check("hsync_low_clocks", hs_cnt, 136);
    check("hsync_first_h", hs_first, 1048);
    check("hsync_last_h", hs_last, 1183);
    check("vsync_low_lines", vs_cnt, 3);
    check("vsync_first_line", vs_first, 14);
    check("vsync_last_line", vs_last, 16);
    check("frame_start_count", fs_cnt, 1);
    check("frame_start_pos", {fs_h[15:0], fs_v[15:0]}, 32'h0);
    check("line_start_count", ls_cnt, V_TOT);
    check("test_pixel_h130", tp130, exp130);
    check("test_pixel_h900", tp900, exp900);
    check("test_pixel_h1100", tp1100, 8'h00);

    // pix_en toggling: advance on every second clock, starting from (0,0)
    ls_seen = 0; ls_t0 = -1; ls_t1 = -1;
    run_ls = 0; run_fs = 0; max_run = 0; bad_hold = 0; bad_pulse_off = 0;
    for (int k = 0; k < 2 * 2 * H_TOT; k++) begin
      prev_h = hcount;
      pix_en = k[0];
      step();
      if (pix_en == 1'b0) begin
        if (hcount !== prev_h) bad_hold++;
        if (line_start !== 1'b0 || frame_start !== 1'b0) bad_pulse_off++;
      end
      run_ls = (line_start === 1'b1) ? run_ls + 1 : 0;
      run_fs = (frame_start === 1'b1) ? run_fs + 1 : 0;
      if (run_ls > max_run) max_run = run_ls;
      if (run_fs > max_run) max_run = run_fs;
      if (line_start === 1'b1) begin
        ls_seen++;
        if (ls_t0 < 0) ls_t0 = k;
        else if (ls_t1 < 0) ls_t1 = k;
      end
    end
    check("toggle_first_line_start", ls_t0, 2687);
    check("toggle_line_period", ls_t1 - ls_t0, 2688);
    check("toggle_line_start_count", ls_seen, 2);
    check("toggle_hold_errs", bad_hold, 0);
    check("toggle_pulse_when_idle", bad_pulse_off, 0);
    check("toggle_max_pulse_len", max_run, 1);
    check("toggle_end_pos", {5'd0, hcount, vcount}, {5'd0, 11'd0, 10'd2});

    // Run into hsync/vsync/blank at (1100,15), then reset mid-frame
    pix_en = 1'b1;
    repeat (13 * H_TOT + 1100) step();
    check("pre_rst_pos", {5'd0, hcount, vcount}, {5'd0, 11'd1100, 10'd15});
    check("pre_rst_ctrl", {hsync, vsync, blank}, 3'b001);
    rst = 1'b1;
    step();
    check("mid_rst_pos", {5'd0, hcount, vcount}, 32'h0);
    check("mid_rst_sync", {hsync, vsync}, 2'b11);
    check("mid_rst_blank", blank, 0);
    check("mid_rst_pulses", {frame_start, line_start}, 2'b00);
    check("mid_rst_test_pixel", test_pixel, 0);
    rst = 1'b0;
    step();
    check("post_rst_first_step", {5'd0, hcount, vcount}, {5'd0, 11'd1, 10'd0});
    check("post_rst_no_line_start", line_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
